fp_divider: RTL and testbench

- Sequential IEEE-754 single-precision divider; the inverse-operation companion to the shift-accumulate fp_multiplier in the same FP datapath.
- Computes inputM / inputQ using iterative restoring division of the 24-bit mantissas.
- Uses a start/busy/done handshake and a fixed latency of QBITS+2 cycles.
- Rounds round-to-nearest-even; flushes denormals to zero; raises of/uf/dz/nv flags.

---
 rtl/fp_divider_pkg.sv | 16 +
 rtl/fp_divider_mant_restoring_div.sv | 40 ++++
 rtl/fp_divider.sv | 123 ++++++++++++
 tb/tb_fp_divider.sv | 118 +++++++++++
 4 files changed

// File: rtl/fp_divider_pkg.sv
// fp_pkg: shared FP constants, FSM state type and IEEE single field extraction
package fp_pkg;
  localparam int EXP_BIAS = 127;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int MANT_W = 23;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, ROUND} state_t;
  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] frac;
  } fp_t;
  function automatic fp_t to_fp(input logic [31:0] x);
    return fp_t'(x);
  endfunction
endpackage

// File: rtl/fp_divider_mant_restoring_div.sv
// mant_restoring_div: one restoring step per cycle on 24-bit mantissas; load(ma,mb), step -> q, rem_nz, last
module mant_restoring_div #(
  parameter int QBITS = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [23:0]      ma,
  input  logic [23:0]      mb,
  output logic [QBITS-1:0] q,
  output logic             rem_nz,
  output logic             last
);
  localparam int CW = $clog2(QBITS);
  logic [24:0]   rem;
  logic [24:0]   keep;
  logic [25:0]   diff;
  logic [CW-1:0] cnt;
  always_comb begin
    diff = {1'b0, rem} - {2'b0, mb};
    keep = diff[25] ? rem : diff[24:0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rem <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= {1'b0, ma};
      q   <= '0;
      cnt <= '0;
    end else if (step) begin
      rem <= keep << 1;
      q   <= {q[QBITS-2:0], ~diff[25]};
      cnt <= cnt + CW'(1);
    end
  assign rem_nz = |rem;
  assign last   = cnt == CW'(QBITS-1);
endmodule

// File: rtl/fp_divider.sv
// fp_divider: sequential IEEE single divide inputM/inputQ; start/busy/done handshake, out+of/uf/dz/nv valid on done
module fp_divider
  import fp_pkg::*;
#(
  parameter int QBITS    = 26,
  parameter int EXP_BIAS = fp_pkg::EXP_BIAS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] inputM,
  input  logic [31:0] inputQ,
  output logic [31:0] out,
  output logic        of,
  output logic        uf,
  output logic        dz,
  output logic        nv,
  output logic        busy,
  output logic        done
);
  state_t            state, state_n;
  logic [31:0]       m_r, q_r;
  fp_t               m_f, q_f;
  logic              m_zero, q_zero;
  logic              sign_r, nv_s, dz_s, zero_s;
  logic signed [9:0] e_r;
  logic              load, step, last, rem_nz;
  logic [QBITS-1:0]  q;
  logic [QBITS-1:0]  t;
  logic [23:0]       mant, sum;
  logic              g, s, inc, carry, fin, r_of, r_uf;
  logic signed [9:0] e1, e2;
  logic [31:0]       res;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE   ? (start ? UNPACK : IDLE) :
              state == UNPACK ? DIVIDE :
              state == DIVIDE ? (last ? ROUND : DIVIDE) : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    load = state == UNPACK;
    step = state == DIVIDE;
  end
  assign m_f    = to_fp(m_r);
  assign q_f    = to_fp(q_r);
  assign m_zero = m_f.exp == 8'd0;
  assign q_zero = q_f.exp == 8'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      m_r    <= '0;
      q_r    <= '0;
      sign_r <= 1'b0;
      e_r    <= '0;
      nv_s   <= 1'b0;
      dz_s   <= 1'b0;
      zero_s <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        m_r <= inputM;
        q_r <= inputQ;
      end
      if (state == UNPACK) begin
        sign_r <= m_f.sign ^ q_f.sign;
        e_r    <= 10'(int'(m_f.exp) - int'(q_f.exp) + EXP_BIAS);
        nv_s   <= m_f.exp == EXP_MAX || q_f.exp == EXP_MAX || (m_zero && q_zero);
        dz_s   <= q_zero && !m_zero && m_f.exp != EXP_MAX;
        zero_s <= m_zero;
      end
    end
  mant_restoring_div #(.QBITS(QBITS)) u_div (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .ma    ({1'b1, m_f.frac}),
    .mb    ({1'b1, q_f.frac}),
    .q     (q),
    .rem_nz(rem_nz),
    .last  (last)
  );
  always_comb begin
    t     = q[QBITS-1] ? q : q << 1;
    mant  = t[QBITS-1 -: 24];
    g     = t[QBITS-25];
    s     = |t[QBITS-26:0] | rem_nz;
    inc   = g & (s | mant[0]);
    sum   = mant + {23'd0, inc};
    carry = ~sum[23];
    e1    = q[QBITS-1] ? e_r : e_r - 10'sd1;
    e2    = e1 + (carry ? 10'sd1 : 10'sd0);
    r_of  = e2 >= 10'sd255;
    r_uf  = e2 <= 10'sd0;
    fin   = ~(nv_s | dz_s | zero_s);
    res   = nv_s            ? QNAN :
            dz_s            ? {sign_r, EXP_MAX, 23'd0} :
            zero_s          ? {sign_r, 31'd0} :
            r_of            ? {sign_r, EXP_MAX, 23'd0} :
            r_uf            ? {sign_r, 31'd0} :
                              {sign_r, e2[7:0], sum[22:0]};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out  <= '0;
      of   <= 1'b0;
      uf   <= 1'b0;
      dz   <= 1'b0;
      nv   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == ROUND;
      if (state == IDLE && start) {of, uf, dz, nv} <= '0;
      if (state == ROUND) begin
        out <= res;
        of  <= fin & r_of;
        uf  <= fin & ~r_of & r_uf;
        dz  <= dz_s;
        nv  <= nv_s;
      end
    end
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: scoreboard bench for fp_divider with directed vectors
module tb_fp_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] inputM = '0;
  logic [31:0] inputQ = '0;
  logic [31:0] out;
  logic        of, uf, dz, nv, busy, done;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  logic [35:0] exp_q[$];
  int          cyc_q[$];
  fp_divider dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .inputM(inputM),
    .inputQ(inputQ),
    .out   (out),
    .of    (of),
    .uf    (uf),
    .dz    (dz),
    .nv    (nv),
    .busy  (busy),
    .done  (done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [31:0] m, input logic [31:0] d, input logic [31:0] eo,
                       input logic [3:0] ef, input bit push);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    inputM = m;
    inputQ = d;
    start  = 1'b1;
    if (push) begin
      exp_q.push_back({eo, ef});
      cyc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [35:0] e;
        int sc;
        e  = exp_q.pop_front();
        sc = cyc_q.pop_front();
        chk("out", out, e[35:4]);
        chk("flags_of_uf_dz_nv", {28'd0, of, uf, dz, nv}, {28'd0, e[3:0]});
        chk("latency", 32'(cyc - sc), 32'd28);
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out", out, 32'd0);
    chk("reset_flags_busy_done", {26'd0, of, uf, dz, nv, busy, done}, 32'd0);
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1);
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1);
    issue(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 1);
    issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 1);
    issue(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 1);
    issue(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1);
    issue(32'h00000000, 32'h4EA0C8E4, 32'h00000000, 4'b0000, 1);
    issue(32'h7F800000, 32'h3F800000, 32'h7FC00000, 4'b0001, 1);
    issue(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b1000, 1);
    issue(32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 1);
    drain();
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1);
    start  = 1'b1;
    inputM = 32'h3F800000;
    inputQ = 32'h40400000;
    repeat (12) @(negedge clk);
    chk("busy_during_op", {31'd0, busy}, 32'd1);
    start = 1'b0;
    drain();
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out", out, 32'd0);
    chk("abort_flags_busy_done", {26'd0, of, uf, dz, nv, busy, done}, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_after_abort", {30'd0, busy, done}, 32'd0);
    issue(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 1);
    drain();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
